// File: rtl/tap_load_shifter_if.sv
// Tap-bank write port, start request and beat stream of tap_load_shifter; master = writer/sink side.
// Latency: none (pure wiring). Backpressure: out_ready from the sink stalls the beat stream.
// Slave is the shifter itself.
interface tap_load_shifter_if #(
    parameter int WIDTH = 8,
    parameter int SEL_W = 2
);
    logic             wr_en;
    logic [SEL_W-1:0] wr_sel;
    logic [WIDTH-1:0] wr_data;
    logic             start;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [SEL_W-1:0] out_idx;
    logic             done;

    modport master (
        output wr_en, wr_sel, wr_data, start, out_ready,
        input  busy, out_valid, out_data, out_idx, done
    );

    modport slave (
        input  wr_en, wr_sel, wr_data, start, out_ready,
        output busy, out_valid, out_data, out_idx, done
    );
endinterface

// File: rtl/tap_load_shifter.sv
// Parallel-load bank of DEPTH taps streamed out tap[DEPTH-1]..tap[0]; macro TAP_LOAD_SHIFTER_CLEAR_ON_DONE_EN clears the bank on DONE.
// Latency: first beat the cycle after start, done one cycle after the last accepted beat.
// Backpressure: out_ready low holds the current beat stable; no timeout.
module tap_load_shifter #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int SEL_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    tap_load_shifter_if.slave    bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_tap [DEPTH];
    logic [SEL_W-1:0] r_idx;
    logic             r_busy;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_idx;
    logic             r_done;

    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(DEPTH - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_idx   <= '0;
            r_done      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tap[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.wr_en) begin
                        r_tap[bus.wr_sel] <= bus.wr_data;
                    end
                    if (bus.start) begin
                        r_state     <= ST_SHIFT;
                        r_idx       <= LAST_IDX;
                        r_busy      <= 1'b1;
                        r_out_valid <= 1'b1;
                        r_out_idx   <= LAST_IDX;
                        // Same-cycle write to the first tap must appear in the first beat.
                        r_out_data  <= (bus.wr_en && bus.wr_sel == LAST_IDX) ? bus.wr_data
                                                                              : r_tap[LAST_IDX];
                    end
                end
                ST_SHIFT: begin
                    if (bus.out_ready) begin
                        if (r_idx != '0) begin
                            r_idx      <= r_idx - 1'b1;
                            r_out_idx  <= r_idx - 1'b1;
                            r_out_data <= r_tap[r_idx - 1'b1];
                        end else begin
                            r_state     <= ST_DONE;
                            r_out_valid <= 1'b0;
                            r_out_data  <= '0;
                            r_out_idx   <= '0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
`ifdef TAP_LOAD_SHIFTER_CLEAR_ON_DONE_EN
                    for (int i = 0; i < DEPTH; i++) begin
                        r_tap[i] <= '0;
                    end
`else
                    // Bank is kept so the next start replays the same beats.
`endif
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_out_data  <= '0;
                    r_out_idx   <= '0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_idx   = r_out_idx;
    assign bus.done      = r_done;
endmodule

// File: tb/tb_tap_load_shifter.sv
// Directed bench for tap_load_shifter: load, stream, backpressure, ignored inputs, reset abort.
module tb_tap_load_shifter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tap_load_shifter_if #(.WIDTH(8), .SEL_W(2)) bus ();

    tap_load_shifter #(.WIDTH(8), .DEPTH(4), .SEL_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] t3, input logic [7:0] t2,
                        input logic [7:0] t1, input logic [7:0] t0);
        logic [31:0] v;
        v = {t3, t2, t1, t0};
        for (int i = 0; i < 4; i++) begin
            bus.wr_en   = 1'b1;
            bus.wr_sel  = 2'(i);
            bus.wr_data = v[8*i +: 8];
            tick();
        end
        bus.wr_en = 1'b0;
    endtask

    // beats[31:24] is the first beat expected (tap3).
    task automatic stream(input string tag, input logic [31:0] beats,
                          input logic [7:0] pat, input bit inj);
        int   k;
        int   p;
        logic r;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        k = 0;
        p = 0;
        while (k < 4 && p < 40) begin
            chk({tag, " valid"}, 32'(bus.out_valid), 32'd1);
            chk({tag, " data"},  32'(bus.out_data), 32'(beats[31-8*k -: 8]));
            chk({tag, " idx"},   32'(bus.out_idx), 32'(3 - k));
            chk({tag, " busy"},  32'(bus.busy), 32'd1);
            chk({tag, " done_early"}, 32'(bus.done), 32'd0);
            if (inj && p == 1) begin
                bus.wr_en = 1'b1; bus.wr_sel = 2'd3; bus.wr_data = 8'hFF; bus.start = 1'b1;
            end else if (inj && p == 2) begin
                bus.wr_en = 1'b0; bus.start = 1'b0;
            end
            r = pat[7 - (p % 8)];
            bus.out_ready = r;
            tick();
            if (r) k++;
            p++;
        end
        if (k < 4) chk({tag, " timeout_beats"}, 32'(k), 32'd4);
        bus.out_ready = 1'b0;
        bus.wr_en = 1'b0;
        bus.start = 1'b0;
        chk({tag, " done"},       32'(bus.done), 32'd1);
        chk({tag, " valid_end"},  32'(bus.out_valid), 32'd0);
        chk({tag, " data_end"},   32'(bus.out_data), 32'd0);
        chk({tag, " busy_done"},  32'(bus.busy), 32'd1);
        tick();
        chk({tag, " done_clr"},   32'(bus.done), 32'd0);
        chk({tag, " busy_clr"},   32'(bus.busy), 32'd0);
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.wr_sel = '0; bus.wr_data = '0;
        bus.start = 1'b0; bus.out_ready = 1'b0;

        // Reset then stream of zeros.
        tick(); tick();
        chk("rst busy",  32'(bus.busy), 32'd0);
        chk("rst valid", 32'(bus.out_valid), 32'd0);
        chk("rst done",  32'(bus.done), 32'd0);
        chk("rst data",  32'(bus.out_data), 32'd0);
        chk("rst idx",   32'(bus.out_idx), 32'd0);
        rst_n = 1'b1;
        tick();
        stream("zero", 32'h00000000, 8'hFF, 1'b0);

        // Ordered load, ready held.
        load(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        stream("ordered", 32'hA1B2C3D4, 8'hFF, 1'b0);

        // Backpressure pattern 0,1,0,0,1,1,0,1.
        load(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        stream("bp", 32'hA1B2C3D4, 8'b01001101, 1'b0);

        // Write and start during SHIFT are ignored.
        load(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        stream("ign", 32'hA1B2C3D4, 8'hFF, 1'b1);
        for (int i = 0; i < 3; i++) begin
            chk("ign no_restart", 32'(bus.busy), 32'd0);
            tick();
        end
`ifdef TAP_LOAD_SHIFTER_CLEAR_ON_DONE_EN
        stream("replay", 32'h00000000, 8'hFF, 1'b0);
`else
        stream("replay", 32'hA1B2C3D4, 8'hFF, 1'b0);
`endif

        // Simultaneous write of tap3 and start.
        load(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        bus.wr_en = 1'b1; bus.wr_sel = 2'd3; bus.wr_data = 8'h5A;
        stream("simul", 32'h5AB2C3D4, 8'hFF, 1'b0);

        // Reset mid-stream after two beats accepted.
        load(8'hA1, 8'hB2, 8'hC3, 8'hD4);
        bus.out_ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        chk("mid beat3", 32'(bus.out_data), 32'hC3);
        rst_n = 1'b0;
        #1;
        chk("mid valid", 32'(bus.out_valid), 32'd0);
        chk("mid busy",  32'(bus.busy), 32'd0);
        chk("mid done",  32'(bus.done), 32'd0);
        chk("mid data",  32'(bus.out_data), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("mid no_done", 32'(bus.done), 32'd0);
            chk("mid no_busy", 32'(bus.busy), 32'd0);
        end
        bus.out_ready = 1'b0;
        stream("post_rst", 32'h00000000, 8'hFF, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tap_load_shifter.md
# tap_load_shifter

Parallel-load, serial-out companion to the 4-tap 8-bit DFF delay line. Software or upstream logic writes each of the four taps by index, then one start pulse streams them out oldest-tap-first (tap 3 down to tap 0) over a valid/ready handshake. The output stream fed into the delay line's `d0`, one beat per clock, rebuilds the same tap contents there. The block sits ahead of the delay line and acts as its writer/transmitter.

## Interface
- `WIDTH`, 8, data width of each tap
- `DEPTH`, 4, number of taps; fixed at 4 in this revision
- `SEL_W`, 2, tap index width, equal to clog2(`DEPTH`)
- `clk`  in  1  rising-edge clock; the block's only clock
- `rst_n`  in  1  reset, asynchronous and active-low
- `wr_en`  in  1  tap write strobe
- `wr_sel`  in  SEL_W  index of the tap to write
- `wr_data`  in  WIDTH  data to write into the tap
- `start`  in  1  single-cycle request to stream the bank out
- `busy`  out  1  high while state is not IDLE
- `out_valid`  out  1  `out_data` holds a valid beat
- `out_ready`  in  1  the sink accepts the beat
- `out_data`  out  WIDTH  current beat; reads 0 when `out_valid` is 0
- `out_idx`  out  SEL_W  tap index of the current beat; reads 0 when `out_valid` is 0
- `done`  out  1  one-cycle pulse after the last beat is accepted

## Operation
- Storage is a bank of `DEPTH` registers, `tap[0..3]`, each `WIDTH` bits. The block also holds a `SEL_W` down-counter `idx` and a 2-bit state register.
- FSM states:
  - **IDLE**
    - `wr_en` writes `tap[wr_sel] <= wr_data`.
    - `start` loads `idx <= DEPTH-1` and moves the FSM to SHIFT.
  - **SHIFT**
    - `out_valid = 1`, `out_data = tap[idx]`, `out_idx = idx`.
    - On a handshake (`out_valid & out_ready`) with `idx != 0`, decrement `idx`.
    - On a handshake with `idx == 0`, go to DONE.
    - With no handshake, hold `idx`; `out_data` must stay stable.
  - **DONE**
    - Lasts exactly one cycle: `done = 1`, then return to IDLE.
- The bank is preserved across the stream unless the configuration macro says otherwise, so repeated starts replay the same data.
- `wr_en` outside IDLE is ignored and the bank does not change.
- `start` outside IDLE is ignored; it is not queued.
- `wr_en` and `start` in the same IDLE cycle: the write lands first, so the stream includes the new value.
- Reset, asserted at any time including mid-stream:
  - all taps, `idx` and state clear immediately;
  - all outputs go to 0;
  - the partial stream is abandoned and `done` does not fire.
- An out-of-range `wr_sel` cannot occur while `DEPTH` equals 2^`SEL_W`.

## Timing
- `start` sampled high at edge N:
  - `busy` and `out_valid` are high from cycle N+1;
  - `out_data` equals `tap[3]` in cycle N+1.
- With `out_ready` held at 1:
  - beats `tap[3]`, `tap[2]`, `tap[1]`, `tap[0]` appear in cycles N+1 to N+4;
  - `done` is high in cycle N+5;
  - `busy` drops in cycle N+6;
  - the earliest accepted restart is sampled at edge N+6.
- Each cycle with `out_ready = 0` stretches the stream by one cycle. There is no timeout.
- `out_valid` never drops mid-stream until the final handshake.
- All outputs decode from registers, with no combinational path from inputs. The one exception is that the handshake is qualified by `out_ready` at the clock edge.

## Configuration
- Macro: `TAP_LOAD_SHIFTER_CLEAR_ON_DONE_EN`.
- Defined: in the DONE cycle, all taps clear to 0. A second `start` with no new writes streams four zero beats.
- Undefined: taps hold their contents after DONE. A second `start` replays the identical four beats.
- Reset clears the taps in both builds.

## Test plan
- Reset then stream:
  - stimulus: hold `rst_n = 0` for 2 cycles, release, pulse `start` with `out_ready = 1`;
  - response: beats 00,00,00,00 with `out_idx` 3,2,1,0; `done` one cycle after the 4th beat.
- Ordered load:
  - stimulus: write tap0 = D4, tap1 = C3, tap2 = B2, tap3 = A1, then `start` with `out_ready = 1`;
  - response: `out_data` A1, B2, C3, D4 on consecutive cycles N+1 to N+4; `done` at N+5.
- Backpressure:
  - stimulus: same load, `out_ready` toggling 0,1,0,0,1,1,0,1;
  - response: each beat is held stable until accepted; order is A1, B2, C3, D4; `done` follows the 4th acceptance by one cycle.
- Ignored inputs:
  - stimulus: during SHIFT, `wr_en` with `wr_sel = 3`, `wr_data = FF`, plus a `start` pulse;
  - response: the stream is unchanged, no second stream runs, and `tap3` still reads A1 on replay. Without the macro, the replay gives A1, B2, C3, D4.
- Simultaneous write and start in IDLE:
  - stimulus: `wr_en` with `wr_sel = 3`, `wr_data = 5A` in the same cycle as `start`;
  - response: the first beat is 5A.
- Reset mid-stream:
  - stimulus: drop `rst_n` after the 2nd beat;
  - response: `out_valid`, `busy` and `done` go to 0 immediately; no `done` pulse follows.
- Macro-defined build:
  - stimulus: after an A1..D4 stream completes, pulse `start` again with no new writes;
  - response: 00,00,00,00.
